// File: rtl/relu_quant_pack.sv
`default_nettype none
// ============================================================================
// Module   : relu_quant_pack
// Purpose  : Takes serialized signed BN results, one channel per beat. Each
//            beat goes through ReLU, a right-shift requantization and unsigned
//            saturation to WIDTH_Q bits. PACK consecutive channels are packed
//            into one wide word for the next layer's line buffer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   i_sclk   in   clock
//   i_rstn   in   asynchronous active-low reset
//   i_vsync  in   frame-start pulse (clears lane/channel counters)
//   i_hsync  in   line-start pulse (sideband only)
//   i_reuse  in   parameter-reuse pulse (sideband only)
//   i_valid  in   input beat valid
//   i_tdata  in   [WIDTH_I] signed BN result for one channel
//   o_vsync  out  i_vsync delayed by 2 cycles
//   o_hsync  out  i_hsync delayed by 2 cycles
//   o_reuse  out  i_reuse delayed by 2 cycles
//   o_valid  out  packed word valid, single-cycle pulse
//   o_tdata  out  [WIDTH_Q*PACK] packed channels, lane 0 in the LSBs
//   o_last   out  word holds channel CHANNEL-1 of a pixel (qualifies o_valid)
//   o_frag   out  one-cycle pulse: a partial group was discarded at vsync
// Build option:
//   RELU_QUANT_ROUND_EN  defined -> round-half-up before the shift,
//                        undefined -> truncation.
// ============================================================================
module relu_quant_pack #(
  parameter int WIDTH_I = 27,
  parameter int WIDTH_Q = 8,
  parameter int SHIFT   = 8,
  parameter int PACK    = 8,
  parameter int CHANNEL = 64
) (
  input  logic                     i_sclk,
  input  logic                     i_rstn,
  input  logic                     i_vsync,
  input  logic                     i_hsync,
  input  logic                     i_reuse,
  input  logic                     i_valid,
  input  logic [WIDTH_I-1:0]       i_tdata,
  output logic                     o_vsync,
  output logic                     o_hsync,
  output logic                     o_reuse,
  output logic                     o_valid,
  output logic [WIDTH_Q*PACK-1:0]  o_tdata,
  output logic                     o_last,
  output logic                     o_frag
);

  localparam int c_LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int c_CH_W   = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam logic [c_LANE_W-1:0] c_LANE_MAX = c_LANE_W'(PACK - 1);
  localparam logic [c_CH_W-1:0]   c_CH_LAST  = c_CH_W'(CHANNEL - PACK);
  localparam logic [c_CH_W-1:0]   c_CH_STEP  = c_CH_W'(PACK);
`ifdef RELU_QUANT_ROUND_EN
  localparam logic [WIDTH_I:0]    c_HALF     = (WIDTH_I + 1)'(1) << (SHIFT - 1);
`endif

  // --------------------------------------------------------------------------
  // Stage 1: ReLU + requantization + saturation
  // --------------------------------------------------------------------------
  logic [WIDTH_I:0]    w_ext;
  logic [WIDTH_I:0]    w_sum;
  logic [WIDTH_I:0]    w_t;
  logic                w_sat;
  logic [WIDTH_Q-1:0]  w_q;

  always_comb begin
    // One extra bit of headroom so the rounding add cannot wrap.
    w_ext = {1'b0, i_tdata};
`ifdef RELU_QUANT_ROUND_EN
    w_sum = w_ext + c_HALF;
`else
    w_sum = w_ext;
`endif
    w_t   = w_sum >> SHIFT;
    w_sat = |w_t[WIDTH_I:WIDTH_Q];
    if (i_tdata[WIDTH_I-1]) begin
      w_q = '0;
    end else if (w_sat) begin
      w_q = '1;
    end else begin
      w_q = w_t[WIDTH_Q-1:0];
    end
  end

  logic                r_s1_valid;
  logic [WIDTH_Q-1:0]  r_s1_q;
  // First sideband stage doubles as the vsync marker aligned to stage-1 data.
  logic                r_vs_d1, r_hs_d1, r_ru_d1;
  logic                r_vs_d2, r_hs_d2, r_ru_d2;

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_q     <= '0;
      r_vs_d1    <= 1'b0;
      r_hs_d1    <= 1'b0;
      r_ru_d1    <= 1'b0;
      r_vs_d2    <= 1'b0;
      r_hs_d2    <= 1'b0;
      r_ru_d2    <= 1'b0;
    end else begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_q <= w_q;
      end
      r_vs_d1 <= i_vsync;
      r_hs_d1 <= i_hsync;
      r_ru_d1 <= i_reuse;
      r_vs_d2 <= r_vs_d1;
      r_hs_d2 <= r_hs_d1;
      r_ru_d2 <= r_ru_d1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: lane packing
  // A vsync travels alongside the beat that arrived with it, so the counters
  // are cleared here one cycle later than the input; the beat that came with
  // vsync then lands in lane 0 of the new frame.
  // --------------------------------------------------------------------------
  logic [c_LANE_W-1:0]      r_lane;
  logic [c_CH_W-1:0]        r_chan;
  logic [WIDTH_Q*PACK-1:0]  r_pack;
  logic [WIDTH_Q*PACK-1:0]  r_tdata;
  logic                     r_valid;
  logic                     r_last;
  logic                     r_frag;

  logic [c_LANE_W-1:0]      w_lane;
  logic [c_CH_W-1:0]        w_chan;
  logic                     w_done;
  logic                     w_ch_last;
  logic [WIDTH_Q*PACK-1:0]  w_word;

  always_comb begin
    w_lane    = r_vs_d1 ? '0 : r_lane;
    w_chan    = r_vs_d1 ? '0 : r_chan;
    w_done    = r_s1_valid && (w_lane == c_LANE_MAX);
    w_ch_last = (w_chan == c_CH_LAST);
    w_word    = r_pack;
    w_word[w_lane*WIDTH_Q +: WIDTH_Q] = r_s1_q;
  end

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_lane  <= '0;
      r_chan  <= '0;
      r_pack  <= '0;
      r_tdata <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_frag  <= 1'b0;
    end else begin
      if (r_s1_valid) begin
        r_pack <= w_word;
        r_lane <= w_done ? '0 : w_lane + c_LANE_W'(1);
      end else begin
        r_lane <= w_lane;
      end

      if (w_done) begin
        r_chan  <= w_ch_last ? '0 : w_chan + c_CH_STEP;
        r_tdata <= w_word;
      end else begin
        r_chan  <= w_chan;
      end

      r_valid <= w_done;
      r_last  <= w_done && w_ch_last;
      // Partial group still open when the frame restarts.
      r_frag  <= r_vs_d1 && (r_lane != '0);
    end
  end

  assign o_vsync = r_vs_d2;
  assign o_hsync = r_hs_d2;
  assign o_reuse = r_ru_d2;
  assign o_valid = r_valid;
  assign o_tdata = r_tdata;
  assign o_last  = r_last;
  assign o_frag  = r_frag;

endmodule
`default_nettype wire
